alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised successor to the single-cycle integer ALU in the execution unit. It adds RV32M multiply, divide and remainder operations, a valid/ready handshake on both sides and a registered result. The execution stage issues one operation at a time and stalls while the block is busy. Base ALU operations complete in one cycle. Multiply and divide run iteratively, one bit per cycle.

## Interface
- XLEN, 32: operand and result width; must be ≥ 8 and even.
- clk_i  in  1  clock; all state changes on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- valid_i  in  1  operation offered.
- ready_o  out  1  block accepts an operation this cycle.
- op_i  in  5  operation code:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - all other codes are illegal.
- s1_i  in  XLEN  first operand.
- s2_i  in  XLEN  second operand.
- flush_i  in  1  abort the in-flight operation.
- valid_o  out  1  result available.
- ready_i  in  1  consumer takes the result.
- d_o  out  XLEN  result.
- zero_o  out  1  d_o == 0; valid only while valid_o is high.
- illegal_o  out  1  the result belongs to an illegal or compiled-out op code; d_o is 0.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE.
- Reset values: valid_o=0, d_o=0, zero_o=0, illegal_o=0, ready_o=1, iteration counter=0.
- Acceptance: an operation is accepted when valid_i && ready_o. ready_o = (state==IDLE) || (state==DONE && ready_i).
- Base and illegal ops: the result is computed combinationally and registered, then the FSM goes to DONE.
  - Shift amount is s2_i[log2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned.
- Multiply: enter MUL and run a shift-add over 2·XLEN bits for XLEN iterations.
  - Operands are sign-extended per op: MULH both signed, MULHSU s1 signed, MULHU both unsigned.
  - MUL returns the low XLEN bits of the product; the MULH variants return the high XLEN bits.
- Divide: enter DIV.
  - The restoring divider works on magnitudes for XLEN iterations.
  - Sign fix-up is applied on exit: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
- Special cases, resolved at acceptance with no iteration; the block goes straight to DONE:
  - Divide by zero: quotient = all ones; remainder = s1.
  - Signed overflow (s1 = −2^(XLEN−1), s2 = −1): quotient = s1; remainder = 0.
- DONE: valid_o=1 and the outputs are held stable until ready_i. When ready_i is high, a new operation may be accepted in the same cycle; otherwise the block returns to IDLE.
- flush_i in MUL, DIV or DONE: return to IDLE next cycle and clear valid_o. Any operation offered in that cycle is not accepted.
- flush_i in IDLE has no effect. flush_i has priority over acceptance.
- Operands are captured at acceptance; later changes to s1_i/s2_i have no effect.

## Timing
- Base op: accepted at edge N; valid_o high after edge N+1 (latency 1).
- MUL/DIV: valid_o high after edge N+XLEN+1, i.e. 33 cycles at XLEN=32.
- Divide special cases: latency 1.
- Throughput for back-to-back base ops with ready_i held high: one per cycle.
- Reset assertion mid-operation: all state returns to its reset value immediately, independent of the clock.
- zero_o and illegal_o are registered together with d_o.

## Configuration
- ALU_MDU_DIV_EN defined: DIV/DIVU/REM/REMU are implemented as above.
- ALU_MDU_DIV_EN undefined:
  - The divider datapath and the DIV state are removed.
  - Op codes 20–23 behave as illegal: latency 1, d_o=0, illegal_o=1.
  - Multiply and base ops are unchanged.

## Test plan
- Reset: drive rstn_i low mid-MUL -> valid_o=0 and ready_o=1 immediately; after release, ADD 5+7 -> d_o=12, zero_o=0, one cycle later.
- Base ops: SRA 0x80000000 by 4 -> 0xF8000000; SLT −1 vs 1 -> 1; SLTU −1 vs 1 -> 0; SUB 3−3 -> 0 with zero_o=1. With ready_i held high, back-to-back issue yields one result per cycle.
- Multiply: MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0; MULHU on the same operands -> 0xFFFFFFFE; MULHSU −1 × 2 -> 0xFFFFFFFF. Each has valid_o after exactly 33 cycles.
- Divide: DIV −7/2 -> −3; REM −7/2 -> −1; DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000 / −1 -> 0x80000000 with REM -> 0, both in 1 cycle. Without ALU_MDU_DIV_EN: illegal_o=1 and d_o=0.
- Backpressure: ready_i held low 10 cycles after a MUL completes -> d_o stable and ready_o=0 throughout; result is taken when ready_i rises.
- Flush: assert flush_i at iteration 12 of a DIV -> IDLE next cycle, valid_o never asserted; a following ADD completes normally.

Source files
------------

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - integer ALU with iterative RV32M multiply/divide and valid/ready handshake
// Purpose: one operation in flight; base ops register in one cycle, MUL*/DIV* iterate one bit per cycle.
// Ports: clk_i, rstn_i (async active-low); valid_i/ready_o/op_i/s1_i/s2_i issue side;
//        flush_i aborts; valid_o/ready_i/d_o/zero_o/illegal_o result side.
// Option: ALU_MDU_DIV_EN adds DIV/DIVU/REM/REMU; without it op codes 20-23 are illegal.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] s1_i,
  input  logic [XLEN-1:0] s2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] d_o,
  output logic            zero_o,
  output logic            illegal_o
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] d_q, res_d;
  logic            zero_q, ill_q, ill_d, res_ld;
  logic            accept, mul_start, last;
  // sel_q: MUL* -> return high half; DIV* -> return remainder
  logic            sel_q;

  logic [2*XLEN-1:0] acc_q, mcand_q, mul_add, mul_acc_nx;
  logic [XLEN-1:0]   mplier_q;
  logic              msgn_q, is_mul, m1_sgn;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  assign ready_o   = (state_q == S_IDLE) || (state_q == S_DONE && ready_i);
  assign valid_o   = (state_q == S_DONE);
  assign d_o       = d_q;
  assign zero_o    = zero_q;
  assign illegal_o = ill_q;

  assign accept = valid_i && ready_o && !(flush_i && state_q != S_IDLE);
  assign last   = (cnt_q == SW'(XLEN - 1));
  assign is_mul = (op_i[4:2] == 3'b100);
  assign m1_sgn = op_i[1] ^ op_i[0];  // MULH and MULHSU treat s1 as signed

  // Signed multiplier bit XLEN-1 carries weight -2^(XLEN-1), so the last step subtracts.
  assign mul_add    = mplier_q[0] ? mcand_q : '0;
  assign mul_acc_nx = (last && msgn_q) ? acc_q - mul_add : acc_q + mul_add;

`ifdef ALU_MDU_DIV_EN
  logic [XLEN-1:0] div_rem_q, div_quo_q, div_dvs_q;
  logic            div_qneg_q, div_rneg_q, div_start;
  logic            is_div, div_sgn, s1_neg, s2_neg, div_zero, div_ovf, div_ge;
  logic [XLEN:0]   div_sh, div_diff;
  logic [XLEN-1:0] div_rem_nx, div_quo_nx, div_q_fix, div_r_fix, div_spec;

  assign is_div   = (op_i[4:2] == 3'b101);
  assign div_sgn  = ~op_i[0];
  assign s1_neg   = div_sgn & s1_i[XLEN-1];
  assign s2_neg   = div_sgn & s2_i[XLEN-1];
  assign div_zero = (s2_i == '0);
  assign div_ovf  = div_sgn && (s1_i == {1'b1, {(XLEN-1){1'b0}}}) && (s2_i == '1);
  assign div_spec = div_zero ? (op_i[1] ? s1_i : '1) : (op_i[1] ? '0 : s1_i);

  // Restoring step: dividend bits shift out of div_quo_q as quotient bits shift in.
  assign div_sh     = {div_rem_q, div_quo_q[XLEN-1]};
  assign div_diff   = div_sh - {1'b0, div_dvs_q};
  assign div_ge     = ~div_diff[XLEN];
  assign div_rem_nx = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign div_quo_nx = {div_quo_q[XLEN-2:0], div_ge};
  assign div_q_fix  = div_qneg_q ? -div_quo_nx : div_quo_nx;
  assign div_r_fix  = div_rneg_q ? -div_rem_nx : div_rem_nx;
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_i)
      5'd0:    alu_res = s1_i + s2_i;
      5'd1:    alu_res = s1_i - s2_i;
      5'd2:    alu_res = s1_i << s2_i[SW-1:0];
      5'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(s1_i) < $signed(s2_i)};
      5'd4:    alu_res = {{(XLEN-1){1'b0}}, s1_i < s2_i};
      5'd5:    alu_res = s1_i ^ s2_i;
      5'd6:    alu_res = s1_i >> s2_i[SW-1:0];
      5'd7:    alu_res = $signed(s1_i) >>> s2_i[SW-1:0];
      5'd8:    alu_res = s1_i | s2_i;
      5'd9:    alu_res = s1_i & s2_i;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = '0;
    ill_d     = 1'b0;
    res_ld    = 1'b0;
    mul_start = 1'b0;
`ifdef ALU_MDU_DIV_EN
    div_start = 1'b0;
`endif
    if (flush_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_MUL: begin
          cnt_d = cnt_q + SW'(1);
          if (last) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_ld  = 1'b1;
            res_d   = sel_q ? mul_acc_nx[2*XLEN-1:XLEN] : mul_acc_nx[XLEN-1:0];
          end
        end
`ifdef ALU_MDU_DIV_EN
        S_DIV: begin
          cnt_d = cnt_q + SW'(1);
          if (last) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_ld  = 1'b1;
            res_d   = sel_q ? div_r_fix : div_q_fix;
          end
        end
`endif
        S_DONE: if (ready_i) state_d = S_IDLE;
        default: ;
      endcase
      // Acceptance only happens from IDLE or DONE, so it never collides with an iteration.
      if (accept) begin
        cnt_d = '0;
        if (is_mul) begin
          state_d   = S_MUL;
          mul_start = 1'b1;
`ifdef ALU_MDU_DIV_EN
        end else if (is_div && (div_zero || div_ovf)) begin
          state_d = S_DONE;
          res_ld  = 1'b1;
          res_d   = div_spec;
        end else if (is_div) begin
          state_d   = S_DIV;
          div_start = 1'b1;
`endif
        end else begin
          state_d = S_DONE;
          res_ld  = 1'b1;
          res_d   = alu_ill ? '0 : alu_res;
          ill_d   = alu_ill;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
      sel_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      msgn_q   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_dvs_q  <= '0;
      div_qneg_q <= 1'b0;
      div_rneg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (res_ld) begin
        d_q    <= res_d;
        zero_q <= (res_d == '0);
        ill_q  <= ill_d;
      end
      if (mul_start) begin
        acc_q    <= '0;
        mcand_q  <= {{XLEN{s1_i[XLEN-1] & m1_sgn}}, s1_i};
        mplier_q <= s2_i;
        msgn_q   <= (op_i[1:0] == 2'b01);
        sel_q    <= (op_i[1:0] != 2'b00);
      end else if (state_q == S_MUL) begin
        acc_q    <= mul_acc_nx;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
`ifdef ALU_MDU_DIV_EN
      if (div_start) begin
        div_rem_q  <= '0;
        div_quo_q  <= s1_neg ? -s1_i : s1_i;
        div_dvs_q  <= s2_neg ? -s2_i : s2_i;
        div_qneg_q <= s1_neg ^ s2_neg;
        div_rneg_q <= s1_neg;
        sel_q      <= op_i[1];
      end else if (state_q == S_DIV) begin
        div_rem_q <= div_rem_nx;
        div_quo_q <= div_quo_nx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  op_i = '0;
  logic [31:0] s1_i = '0;
  logic [31:0] s2_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] d_o;
  logic        zero_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_pass = 0;

  alu_mdu #(.XLEN(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .s1_i(s1_i), .s2_i(s2_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .d_o(d_o), .zero_o(zero_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Reference: returns {illegal, result} from plain 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r = '0;
    ill = 1'b0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = 32'(sa >>> b[4:0]);
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd16: begin p = 64'(sa * sb); r = p[31:0]; end
      5'd17: begin p = 64'(sa * sb); r = p[63:32]; end
      5'd18: begin p = 64'(sa * ub); r = p[63:32]; end
      5'd19: begin p = 64'(ua * ub); r = p[63:32]; end
`ifdef ALU_MDU_DIV_EN
      5'd20: if (b == 0) r = '1; else if (a == 32'h80000000 && b == '1) r = a; else r = 32'(sa / sb);
      5'd21: r = (b == 0) ? '1 : a / b;
      5'd22: if (b == 0) r = a; else if (a == 32'h80000000 && b == '1) r = '0; else r = 32'(sa % sb);
      5'd23: r = (b == 0) ? a : a % b;
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd16 && op <= 5'd19) return 33;
`ifdef ALU_MDU_DIV_EN
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h80000000 && b == '1) return 1;
      return 33;
    end
`endif
    return 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Offers one op, scrambles operands after acceptance, and counts edges from the
  // accepting edge until valid_o is seen (1 = visible right after the accepting edge).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic ill, output logic z, output int lat);
    int n;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; s1_i = a; s2_i = b;
    n = 0;
    while (!ready_o && n < 100) begin @(negedge clk_i); n++; end
    @(posedge clk_i); #1;
    valid_i = 1'b0; op_i = 5'($urandom); s1_i = $urandom; s2_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    d = d_o; ill = illegal_o; z = zero_o;
  endtask

  task automatic consume();
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ill, z; int lat;
    @(negedge clk_i); @(negedge clk_i);
    n_checks++;
    if ({valid_o, ready_o} !== 2'b01) $display("FAIL reset_hs: valid/ready=%b required 01", {valid_o, ready_o}); else n_pass++;
    n_checks++;
    if ({d_o, zero_o, illegal_o} !== 34'd0) $display("FAIL reset_out: d=%h z=%b ill=%b required 0", d_o, zero_o, illegal_o); else n_pass++;
    rstn_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 5'd17; s1_i = 32'h1234; s2_i = 32'h5678;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    n_checks++;
    if (ready_o !== 1'b0) $display("FAIL reset_busy: ready_o=%b required 0 mid-MUL", ready_o); else n_pass++;
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ready_o} !== 2'b01) $display("FAIL reset_async: valid/ready=%b required 01", {valid_o, ready_o}); else n_pass++;
    @(negedge clk_i); rstn_i = 1'b1;
    issue(5'd0, 32'd5, 32'd7, d, ill, z, lat);
    n_checks++;
    if ({d, z, ill} !== {32'd12, 1'b0, 1'b0}) $display("FAIL reset_add: d=%h z=%b ill=%b required 0000000c 0 0", d, z, ill); else n_pass++;
    n_checks++;
    if (lat !== 1) $display("FAIL reset_add_lat: %0d required 1", lat); else n_pass++;
    consume();
  endtask

  task automatic test_base();
    logic [4:0] t_op [6]; logic [31:0] t_a [6]; logic [31:0] t_b [6]; logic [31:0] t_d [6]; logic [1:0] t_zi [6];
    logic [31:0] d; logic ill, z; int lat;
    t_op = '{5'd7, 5'd3, 5'd4, 5'd1, 5'd2, 5'd10};
    t_a  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd1, 32'd99};
    t_b  = '{32'd4, 32'd1, 32'd1, 32'd3, 32'd33, 32'd1};
    t_d  = '{32'hF8000000, 32'd1, 32'd0, 32'd0, 32'd2, 32'd0};
    t_zi = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11};
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], d, ill, z, lat);
      n_checks++;
      if (d !== t_d[i]) $display("FAIL base_d[%0d]: d=%h required %h", i, d, t_d[i]); else n_pass++;
      n_checks++;
      if ({z, ill} !== t_zi[i]) $display("FAIL base_flags[%0d]: zero/ill=%b required %b", i, {z, ill}, t_zi[i]); else n_pass++;
      n_checks++;
      if (lat !== 1) $display("FAIL base_lat[%0d]: %0d required 1", i, lat); else n_pass++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    @(negedge clk_i); ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; op_i = 5'($urandom_range(0, 9)); s1_i = rnd_opnd(); s2_i = rnd_opnd();
      e = model(op_i, s1_i, s2_i);
      @(posedge clk_i); #1;
      n_checks++;
      if ({valid_o, d_o} !== {1'b1, e[31:0]}) $display("FAIL b2b[%0d]: valid=%b d=%h required 1 %h", i, valid_o, d_o, e[31:0]); else n_pass++;
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1; ready_i = 1'b0;
  endtask

  task automatic test_mul();
    logic [4:0] t_op [5]; logic [31:0] t_a [5]; logic [31:0] t_b [5]; logic [31:0] t_d [5];
    logic [31:0] d; logic ill, z; int lat;
    t_op = '{5'd17, 5'd19, 5'd18, 5'd16, 5'd17};
    t_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    t_b  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd5, 32'h80000000};
    t_d  = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h40000000};
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i], d, ill, z, lat);
      n_checks++;
      if ({d, ill} !== {t_d[i], 1'b0}) $display("FAIL mul_d[%0d]: d=%h ill=%b required %h 0", i, d, ill, t_d[i]); else n_pass++;
      n_checks++;
      if (lat !== 33) $display("FAIL mul_lat[%0d]: %0d required 33", i, lat); else n_pass++;
      consume();
    end
  endtask

  task automatic test_div();
    logic [4:0] t_op [6]; logic [31:0] t_a [6]; logic [31:0] t_b [6]; logic [31:0] t_d [6]; int t_l [6];
    logic [31:0] d; logic ill, z; int lat;
    t_op = '{5'd20, 5'd22, 5'd21, 5'd22, 5'd20, 5'd22};
    t_a  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
    t_b  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef ALU_MDU_DIV_EN
    t_d  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0};
    t_l  = '{33, 33, 1, 1, 1, 1};
`else
    t_d  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    t_l  = '{1, 1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], d, ill, z, lat);
      n_checks++;
`ifdef ALU_MDU_DIV_EN
      if ({d, ill} !== {t_d[i], 1'b0}) $display("FAIL div_d[%0d]: d=%h ill=%b required %h 0", i, d, ill, t_d[i]); else n_pass++;
`else
      if ({d, ill} !== {t_d[i], 1'b1}) $display("FAIL div_d[%0d]: d=%h ill=%b required %h 1", i, d, ill, t_d[i]); else n_pass++;
`endif
      n_checks++;
      if (lat !== t_l[i]) $display("FAIL div_lat[%0d]: %0d required %0d", i, lat, t_l[i]); else n_pass++;
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, a, b; logic ill, z; int lat; logic [32:0] e;
    a = $urandom; b = $urandom;
    e = model(5'd19, a, b);
    issue(5'd19, a, b, d, ill, z, lat);
    n_checks++;
    if ({d, lat} !== {e[31:0], 32'd33}) $display("FAIL bp_mul: d=%h lat=%0d required %h 33", d, lat, e[31:0]); else n_pass++;
    // Offer an ADD while stalled; it must wait until ready_i rises.
    valid_i = 1'b1; op_i = 5'd0; s1_i = 32'd40; s2_i = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({valid_o, ready_o, d_o} !== {2'b10, e[31:0]}) $display("FAIL bp_hold[%0d]: valid/ready=%b d=%h required 10 %h", i, {valid_o, ready_o}, d_o, e[31:0]); else n_pass++;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    n_checks++;
    if ({valid_o, d_o} !== {1'b1, 32'd42}) $display("FAIL bp_take: valid=%b d=%h required 1 0000002a", valid_o, d_o); else n_pass++;
    consume();
  endtask

  task automatic test_flush();
    logic [31:0] d; logic ill, z; int lat; logic seen;
    @(negedge clk_i);
`ifdef ALU_MDU_DIV_EN
    valid_i = 1'b1; op_i = 5'd20; s1_i = 32'd100; s2_i = 32'd7;
`else
    valid_i = 1'b1; op_i = 5'd17; s1_i = 32'd100; s2_i = 32'd7;
`endif
    @(posedge clk_i); #1; valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 11; i++) begin @(posedge clk_i); #1; seen |= valid_o; end
    @(negedge clk_i);
    flush_i = 1'b1; valid_i = 1'b1; op_i = 5'd0; s1_i = 32'd1; s2_i = 32'd1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    n_checks++;
    if ({valid_o, ready_o} !== 2'b01) $display("FAIL flush_idle: valid/ready=%b required 01", {valid_o, ready_o}); else n_pass++;
    for (int i = 0; i < 40; i++) begin @(posedge clk_i); #1; seen |= valid_o; end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL flush_novalid: valid_o seen=%b required 0", seen); else n_pass++;
    issue(5'd0, 32'd20, 32'd22, d, ill, z, lat);
    n_checks++;
    if ({d, lat} !== {32'd42, 32'd1}) $display("FAIL flush_add: d=%h lat=%0d required 0000002a 1", d, lat); else n_pass++;
    // flush in DONE beats a same-cycle acceptance
    @(negedge clk_i);
    flush_i = 1'b1; ready_i = 1'b1; valid_i = 1'b1; op_i = 5'd0; s1_i = 32'd3; s2_i = 32'd4;
    @(posedge clk_i); #1;
    flush_i = 1'b0; ready_i = 1'b0; valid_i = 1'b0;
    n_checks++;
    if ({valid_o, ready_o} !== 2'b01) $display("FAIL flush_done: valid/ready=%b required 01", {valid_o, ready_o}); else n_pass++;
    // flush in IDLE is ignored
    @(negedge clk_i);
    flush_i = 1'b1; valid_i = 1'b1; op_i = 5'd0; s1_i = 32'd9; s2_i = 32'd9;
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    n_checks++;
    if ({valid_o, d_o} !== {1'b1, 32'd18}) $display("FAIL flush_in_idle: valid=%b d=%h required 1 00000012", valid_o, d_o); else n_pass++;
    consume();
  endtask

  task automatic test_random();
    logic [31:0] d, a, b; logic ill, z; int lat, el; logic [4:0] op; logic [32:0] e;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1: op = 5'($urandom_range(0, 9));
        2:    op = 5'($urandom_range(16, 19));
        3:    op = 5'($urandom_range(20, 23));
        default: op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(10, 15)) : 5'($urandom_range(24, 31));
      endcase
      a = rnd_opnd(); b = rnd_opnd();
      e = model(op, a, b);
      el = exp_lat(op, a, b);
      issue(op, a, b, d, ill, z, lat);
      n_checks++;
      if (d !== e[31:0]) $display("FAIL rnd_d[%0d] op=%0d a=%h b=%h: d=%h required %h", i, op, a, b, d, e[31:0]); else n_pass++;
      n_checks++;
      if ({ill, z} !== {e[32], e[31:0] == 32'd0}) $display("FAIL rnd_flags[%0d] op=%0d: ill/zero=%b required %b", i, op, {ill, z}, {e[32], e[31:0] == 32'd0}); else n_pass++;
      n_checks++;
      if (lat !== el) $display("FAIL rnd_lat[%0d] op=%0d: %0d required %0d", i, op, lat, el); else n_pass++;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
